fp_add_sequencer: RTL and testbench

Control and wrapper stage around the pipelined fp_ieee754_adder core. It accepts an operand pair over a valid/ready handshake and classifies special cases. Normal operands are issued to the adder with a single Load pulse; the result is captured after a fixed latency, post-checked for overflow, and presented downstream over a valid/ready handshake. Zero, infinity, NaN and exact-cancellation cases bypass the core entirely.

---
 rtl/fp_pkg.sv | 56 +++++
 rtl/fp_special_classifier.sv | 71 +++++++
 rtl/fp_add_sequencer.sv | 126 ++++++++++++
 tb/tb_fp_add_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
//------------------------------------------------------------------------------
// Module      : fp_pkg
// Description : IEEE-754 single-precision field positions, constants, flag
//               indices, sequencer state encoding and the result post-check.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    // out_flags = {nan, inf, zero, bypass}
    localparam int FLAG_NAN    = 3;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_BYPASS = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  flags;
    } fp_result_t;

    // Saturate an all-ones exponent to infinity and flush a zero exponent.
    function automatic fp_result_t post_check(input logic [31:0] sum);
        fp_result_t r;
        r.value = sum;
        r.flags = '0;
        if (sum[EXP_MSB:EXP_LSB] == EXP_MAX) begin
            r.value          = {sum[SIGN_BIT], EXP_MAX, 23'b0};
            r.flags[FLAG_INF] = 1'b1;
        end else if (sum[EXP_MSB:EXP_LSB] == 8'h00) begin
            r.value           = {sum[SIGN_BIT], 31'b0};
            r.flags[FLAG_ZERO] = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_special_classifier.sv
//------------------------------------------------------------------------------
// Module      : fp_special_classifier
// Description : Combinational detection of operand pairs whose sum is known
//               without the adder core (NaN, inf, zero, exact cancellation).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_special_classifier
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] bypass_result,
    output logic [3:0]  bypass_flags
);

    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_ma, w_mb;
    logic        w_zero_a, w_zero_b, w_nan_a, w_nan_b, w_inf_a, w_inf_b;

    assign w_sa = a[SIGN_BIT];
    assign w_sb = b[SIGN_BIT];
    assign w_ea = a[EXP_MSB:EXP_LSB];
    assign w_eb = b[EXP_MSB:EXP_LSB];
    assign w_ma = a[MANT_MSB:0];
    assign w_mb = b[MANT_MSB:0];

    // Denormals are flushed: any zero exponent counts as a signed zero.
    assign w_zero_a = (w_ea == 8'h00);
    assign w_zero_b = (w_eb == 8'h00);
    assign w_nan_a  = (w_ea == EXP_MAX) && (w_ma != '0);
    assign w_nan_b  = (w_eb == EXP_MAX) && (w_mb != '0);
    assign w_inf_a  = (w_ea == EXP_MAX) && (w_ma == '0);
    assign w_inf_b  = (w_eb == EXP_MAX) && (w_mb == '0);

    always_comb begin
        is_special    = 1'b1;
        bypass_result = '0;
        bypass_flags  = '0;
        bypass_flags[FLAG_BYPASS] = 1'b1;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) begin
            bypass_result          = QNAN;
            bypass_flags[FLAG_NAN] = 1'b1;
        end else if (w_inf_a) begin
            bypass_result          = w_sa ? NEG_INF : POS_INF;
            bypass_flags[FLAG_INF] = 1'b1;
        end else if (w_inf_b) begin
            bypass_result          = w_sb ? NEG_INF : POS_INF;
            bypass_flags[FLAG_INF] = 1'b1;
        end else if (w_zero_a && w_zero_b) begin
            bypass_result           = {w_sa & w_sb, 31'b0};
            bypass_flags[FLAG_ZERO] = 1'b1;
        end else if (w_zero_a) begin
            bypass_result = b;
        end else if (w_zero_b) begin
            bypass_result = a;
        end else if ((w_ea == w_eb) && (w_ma == w_mb) && (w_sa != w_sb)) begin
            bypass_result           = '0;
            bypass_flags[FLAG_ZERO] = 1'b1;
        end else begin
            is_special   = 1'b0;
            bypass_flags = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_add_sequencer.sv
//------------------------------------------------------------------------------
// Module      : fp_add_sequencer
// Description : Handshake wrapper around a pipelined FP adder core: issues one
//               load per operand pair, captures and post-checks the sum.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int ADDER_LATENCY = 4,
    parameter int DATA_W        = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_load,
    input  logic [DATA_W-1:0] add_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags
);

    localparam int CNT_W = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(ADDER_LATENCY - 1);

    seq_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_add_a, r_add_b, r_out_result;
    logic [3:0]        r_out_flags;
    logic              r_out_valid;

    logic              w_is_special;
    logic [31:0]       w_bypass_result;
    logic [3:0]        w_bypass_flags;
    fp_result_t        w_post;

    fp_special_classifier u_classifier (
        .a             (in_a),
        .b             (in_b),
        .is_special    (w_is_special),
        .bypass_result (w_bypass_result),
        .bypass_flags  (w_bypass_flags)
    );

    assign w_post = post_check(add_result);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = w_is_special ? RESP : ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (r_out_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt        <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_add_a <= in_a;
                        r_add_b <= in_b;
                        if (w_is_special) begin
                            r_out_result <= w_bypass_result;
                            r_out_flags  <= w_bypass_flags;
                        end
                    end
                end
                ISSUE: r_cnt <= C_CNT_LOAD;
                WAIT: begin
                    // Counter hits zero in the cycle the core presents the sum.
                    if (r_cnt == '0) begin
                        r_out_result <= w_post.value;
                        r_out_flags  <= w_post.flags;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign add_load   = (r_state == ISSUE);
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_fp_add_sequencer
// Description : Directed and randomized self-checking bench for fp_add_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_add_sequencer;

    localparam int LAT = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [31:0] add_a, add_b;
    logic        add_load;
    logic [31:0] add_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    fp_add_sequencer #(.ADDER_LATENCY(LAT), .DATA_W(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_load   (add_load),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    // Adder stand-in: the sum appears exactly LAT cycles after the load cycle
    // and only for that one cycle; every other cycle shows junk.
    logic [31:0] stub_val;
    logic [31:0] pipe [LAT];
    always @(posedge Clk) begin
        pipe[0] <= add_load ? stub_val : 32'h0BAD0BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result = pipe[LAT-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: rules applied on unpacked fields, then post-check of the core sum.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] sum, output logic [31:0] res,
                                      output logic [3:0] flg, output logic byp);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit a_nan  = (ea == 255) && (a[22:0] != 0);
        bit b_nan  = (eb == 255) && (b[22:0] != 0);
        bit a_inf  = (ea == 255) && (a[22:0] == 0);
        bit b_inf  = (eb == 255) && (b[22:0] == 0);
        bit a_zero = (ea == 0);
        bit b_zero = (eb == 0);
        int es     = int'(sum[30:23]);
        byp = 1'b1;
        if (a_nan || b_nan)                       begin res = 32'h7FC00000; flg = 4'b1001; end
        else if (a_inf && b_inf && (a[31] != b[31])) begin res = 32'h7FC00000; flg = 4'b1001; end
        else if (a_inf)                           begin res = a; flg = 4'b0101; end
        else if (b_inf)                           begin res = b; flg = 4'b0101; end
        else if (a_zero && b_zero) begin
            res = (a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
            flg = 4'b0011;
        end
        else if (a_zero)                          begin res = b; flg = 4'b0001; end
        else if (b_zero)                          begin res = a; flg = 4'b0001; end
        else if ((a ^ b) == 32'h80000000)         begin res = 32'h0; flg = 4'b0011; end
        else begin
            byp = 1'b0;
            if (es == 255)    begin res = sum[31] ? 32'hFF800000 : 32'h7F800000; flg = 4'b0100; end
            else if (es == 0) begin res = sum[31] ? 32'h80000000 : 32'h00000000; flg = 4'b0010; end
            else              begin res = sum; flg = 4'b0000; end
        end
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] sum, input int hold);
        logic [31:0] e_res;
        logic [3:0]  e_flg;
        logic        e_byp;
        int k;
        int loads;
        ref_model(a, b, sum, e_res, e_flg, e_byp);
        k = 0;
        while (!in_ready && k < 20) begin @(posedge Clk); #1; k++; end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b; stub_val = sum; out_ready = 1'b0;
        @(posedge Clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        k = 0; loads = 0;
        while (!out_valid && k < 20) begin
            if (add_load) begin
                loads++;
                check("add_a", add_a, a);
                check("add_b", add_b, b);
            end
            @(posedge Clk); #1; k++;
        end
        check("latency", 32'(k), e_byp ? 32'd1 : 32'(LAT + 2));
        check("load_count", 32'(loads), e_byp ? 32'd0 : 32'd1);
        check("result", out_result, e_res);
        check("flags", 32'(out_flags), 32'(e_flg));
        check("in_ready_resp", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
            @(posedge Clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, e_res);
            check("hold_flags", 32'(out_flags), 32'(e_flg));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_add_a", add_a, a);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("back_to_idle", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_fp(input bit allow_special);
        logic [31:0] v = $urandom;
        int sel = allow_special ? int'($urandom_range(0, 7)) : 7;
        case (sel)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       v[30:23] = 8'hFF;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb, rs;
        Reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; stub_val = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_add_load", 32'(add_load), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        Reset = 1'b0;

        run_txn(32'h3F800000, 32'h40000000, 32'h40400000, 0);
        run_txn(32'h7FC00001, 32'h3F800000, 32'h12345678, 0);
        run_txn(32'h7F800000, 32'hFF800000, 32'h12345678, 0);
        run_txn(32'h7F800000, 32'h40A00000, 32'h12345678, 0);
        run_txn(32'h80000000, 32'h80000000, 32'h12345678, 0);
        run_txn(32'h00000001, 32'h3F800000, 32'h12345678, 0);
        run_txn(32'h3FC00000, 32'hBFC00000, 32'h12345678, 0);
        run_txn(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7FA00000, 0);
        run_txn(32'h3F800000, 32'h3F000000, 32'h3FC00000, 3);
        run_txn(32'h40000000, 32'h3F800000, 32'h40400000, 0);

        // Reset during the second WAIT cycle
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; stub_val = 32'h40400000;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("midwait_busy", 32'(in_ready), 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_add_load", 32'(add_load), 32'd0);
        check("abort_add_a", add_a, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_result", out_result, 32'd0);
        run_txn(32'h3F800000, 32'h3F800000, 32'h40000000, 0);

        for (int t = 0; t < 40; t++) begin
            ra = rand_fp(1'b1);
            rb = ($urandom_range(0, 4) == 0) ? (ra ^ 32'h80000000) : rand_fp(1'b1);
            rs = rand_fp($urandom_range(0, 2) == 0);
            run_txn(ra, rb, rs, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
